// File: rtl/vdp_cpu_port.sv
// CPU-side bus port for the VDP: captures CPU bus cycles on cpu_phi2, queues them, replays as vdp pulses.
// Optional VDP_PORT_STATUS_EN: address-3 reads return port status instead of being queued.
module vdp_cpu_port #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_phi2,
  input  logic       cpu_cs,
  input  logic       cpu_rw,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic [1:0] vdp_mode,
  output logic       vdp_write,
  output logic       vdp_read,
  output logic [7:0] vdp_data,
  input  logic       vdp_ready,
  input  logic [7:0] vdp_rdata,
  input  logic       vdp_rvalid,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } entry_t;

  logic             phi2_q;
  logic             sh_cs;
  logic             sh_rw;
  logic [1:0]       sh_addr;
  logic [7:0]       sh_data;
  entry_t           mem [FIFO_DEPTH];
  entry_t           head_c;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt_c;
  logic [7:0]       rd_latch;
  logic             commit_c;
  logic             status_rd_c;
  logic             push_req_c;
  logic             empty_c;
  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;

  // Commit on the first clk edge that sees phi2 low after being high
  assign commit_c = phi2_q & ~cpu_phi2;

`ifdef VDP_PORT_STATUS_EN
  assign status_rd_c = commit_c & sh_cs & sh_rw & (sh_addr == 2'd3);
  assign cpu_rdata   = (cpu_phi2 && sh_addr == 2'd3) ?
                       {fifo_full, overflow, 5'b0_0000, empty_c} : rd_latch;
`else
  assign status_rd_c = 1'b0;
  assign cpu_rdata   = rd_latch;
`endif

  assign push_req_c  = commit_c & sh_cs & ~status_rd_c;
  assign empty_c     = (count == '0);
  assign full_c      = (count == CNT_W'(FIFO_DEPTH));
  assign pop_c       = ~empty_c & vdp_ready;
  assign push_c      = push_req_c & (~full_c | pop_c);
  assign drop_c      = push_req_c & full_c & ~pop_c;
  assign count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
  assign head_c      = mem[rd_ptr];

  // Bus sampling: phi2 delay and shadow of the CPU bus while phi2 is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phi2_q  <= 1'b0;
      sh_cs   <= 1'b0;
      sh_rw   <= 1'b0;
      sh_addr <= 2'd0;
      sh_data <= 8'h00;
    end else begin
      phi2_q <= cpu_phi2;
      if (cpu_phi2) begin
        sh_cs   <= cpu_cs;
        sh_rw   <= cpu_rw;
        sh_addr <= cpu_addr;
        sh_data <= cpu_wdata;
      end
    end
  end

  // Queue storage; contents are don't-care until pointed at by a valid count
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= entry_t'({sh_rw, sh_addr, sh_data});
    end
  end

  // Queue pointers, count and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt_c;
      fifo_full <= (count_nxt_c == CNT_W'(FIFO_DEPTH));
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (status_rd_c) begin
        overflow <= 1'b0;
      end
    end
  end

  // Drain side: one-cycle pulses; mode/data hold between pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vdp_mode  <= 2'd0;
      vdp_data  <= 8'h00;
      vdp_write <= 1'b0;
      vdp_read  <= 1'b0;
    end else begin
      vdp_write <= pop_c & ~head_c.rw;
      vdp_read  <= pop_c & head_c.rw;
      if (pop_c) begin
        vdp_mode <= head_c.addr;
        vdp_data <= head_c.data;
      end
    end
  end

  // Read-ahead latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_latch <= 8'h00;
    end else if (vdp_rvalid) begin
      rd_latch <= vdp_rdata;
    end
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed self-checking bench for vdp_cpu_port (both VDP_PORT_STATUS_EN builds).
module tb_vdp_cpu_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_phi2 = 1'b0;
  logic       cpu_cs = 1'b0;
  logic       cpu_rw = 1'b0;
  logic [1:0] cpu_addr = 2'd0;
  logic [7:0] cpu_wdata = 8'h00;
  logic [7:0] cpu_rdata;
  logic [1:0] vdp_mode;
  logic       vdp_write;
  logic       vdp_read;
  logic [7:0] vdp_data;
  logic       vdp_ready = 1'b1;
  logic [7:0] vdp_rdata = 8'h00;
  logic       vdp_rvalid = 1'b0;
  logic       fifo_full;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_commit = 0;

  typedef struct {
    int         cyc;
    logic       rw;
    logic [1:0] mode;
    logic [7:0] data;
  } pulse_t;
  pulse_t plog[$];

  vdp_cpu_port #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cpu_phi2(cpu_phi2), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .vdp_mode(vdp_mode), .vdp_write(vdp_write), .vdp_read(vdp_read), .vdp_data(vdp_data),
    .vdp_ready(vdp_ready), .vdp_rdata(vdp_rdata), .vdp_rvalid(vdp_rvalid),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every pulse with the index of the clk edge that produced it
  always @(negedge clk) begin
    if (!reset && (vdp_write || vdp_read)) begin
      plog.push_back('{cyc: cyc, rw: vdp_read, mode: vdp_mode, data: vdp_data});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CPU bus cycle: phi2 high 2 clks, low 2 clks; rd sampled late in the high phase
  task automatic cpu_access(input logic rw, input logic [1:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd);
    cpu_cs = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd; cpu_phi2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd = cpu_rdata;
    last_commit = cyc + 1;
    cpu_phi2 = 1'b0;
    @(negedge clk);
    cpu_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", cpu_rdata); end
    checks++; if (vdp_mode !== 2'd0) begin errors++; $display("FAIL rst_mode got %h exp 0", vdp_mode); end
    checks++; if (vdp_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", vdp_data); end
    checks++; if (vdp_write !== 1'b0) begin errors++; $display("FAIL rst_write got %b exp 0", vdp_write); end
    checks++; if (vdp_read !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", vdp_read); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_register_program();
    logic [7:0] rd;
    int c0, c1;
    vdp_ready = 1'b1; idle(3); plog.delete();
    cpu_access(1'b0, 2'd0, 8'h04, rd); c0 = last_commit;
    cpu_access(1'b0, 2'd1, 8'h4F, rd); c1 = last_commit;
    idle(4);
    checks++; if (plog.size() !== 2) begin errors++; $display("FAIL reg_count got %0d exp 2", plog.size()); end
    checks++; if (plog[0].rw !== 1'b0 || plog[0].mode !== 2'd0 || plog[0].data !== 8'h04)
      begin errors++; $display("FAIL reg_p0 got rw=%b mode=%h data=%h exp 0/0/04", plog[0].rw, plog[0].mode, plog[0].data); end
    checks++; if (plog[0].cyc !== c0 + 1) begin errors++; $display("FAIL reg_lat0 got %0d exp %0d", plog[0].cyc, c0 + 1); end
    checks++; if (plog[1].rw !== 1'b0 || plog[1].mode !== 2'd1 || plog[1].data !== 8'h4F)
      begin errors++; $display("FAIL reg_p1 got rw=%b mode=%h data=%h exp 0/1/4f", plog[1].rw, plog[1].mode, plog[1].data); end
    checks++; if (plog[1].cyc !== c1 + 1) begin errors++; $display("FAIL reg_lat1 got %0d exp %0d", plog[1].cyc, c1 + 1); end
    checks++; if (vdp_mode !== 2'd1 || vdp_data !== 8'h4F)
      begin errors++; $display("FAIL reg_hold got mode=%h data=%h exp 1/4f", vdp_mode, vdp_data); end
  endtask

  task automatic test_backpressure();
    logic [7:0] rd;
    int rel;
    vdp_ready = 1'b0; idle(3); plog.delete();
    for (int i = 0; i < 4; i++) begin
      cpu_access(1'b0, 2'd0, 8'h10 + 8'(i), rd);
      if (i == 2) begin
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL bp_full3 got %b exp 0", fifo_full); end
      end
    end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL bp_full got %b exp 1", fifo_full); end
    checks++; if (plog.size() !== 0) begin errors++; $display("FAIL bp_held got %0d pulses exp 0", plog.size()); end
    rel = cyc;
    vdp_ready = 1'b1;
    idle(6);
    checks++; if (plog.size() !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", plog.size()); end
    checks++; if (plog[0].cyc !== rel + 1) begin errors++; $display("FAIL bp_first got %0d exp %0d", plog[0].cyc, rel + 1); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (plog[i].data !== 8'h10 + 8'(i) || plog[i].cyc !== rel + 1 + i || plog[i].rw !== 1'b0)
        begin errors++; $display("FAIL bp_p%0d got data=%h cyc=%0d exp %h/%0d", i, plog[i].data, plog[i].cyc, 8'h10 + 8'(i), rel + 1 + i); end
    end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL bp_empty_full got %b exp 0", fifo_full); end
  endtask

  task automatic test_overflow();
    logic [7:0] rd;
    vdp_ready = 1'b0; idle(3); plog.delete();
    for (int i = 0; i < 5; i++) cpu_access(1'b0, 2'd2, 8'h20 + 8'(i), rd);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", fifo_full); end
`ifdef VDP_PORT_STATUS_EN
    cpu_access(1'b1, 2'd3, 8'h00, rd);
    checks++; if (rd !== 8'hC0) begin errors++; $display("FAIL ovf_stat1 got %h exp c0", rd); end
    cpu_access(1'b1, 2'd3, 8'h00, rd);
    checks++; if (rd !== 8'h80) begin errors++; $display("FAIL ovf_stat2 got %h exp 80", rd); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
`else
    idle(5);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
`endif
    vdp_ready = 1'b1;
    idle(6);
    checks++; if (plog.size() !== 4) begin errors++; $display("FAIL ovf_count got %0d exp 4", plog.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (plog[i].data !== 8'h20 + 8'(i) || plog[i].mode !== 2'd2)
        begin errors++; $display("FAIL ovf_p%0d got data=%h mode=%h exp %h/2", i, plog[i].data, plog[i].mode, 8'h20 + 8'(i)); end
    end
`ifndef VDP_PORT_STATUS_EN
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_rstclr got %b exp 0", overflow); end
`endif
  endtask

  task automatic test_read_ahead();
    logic [7:0] rd;
    int n;
    vdp_ready = 1'b1; idle(3); plog.delete();
    cpu_access(1'b1, 2'd1, 8'h00, rd);
    n = 0;
    while (!vdp_read && n < 10) begin @(negedge clk); n++; end
    checks++; if (vdp_read !== 1'b1 || vdp_mode !== 2'd1)
      begin errors++; $display("FAIL ra_pulse got read=%b mode=%h exp 1/1", vdp_read, vdp_mode); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL ra_before got %h exp 00", cpu_rdata); end
    vdp_rvalid = 1'b1; vdp_rdata = 8'hA5;
    @(negedge clk);
    vdp_rvalid = 1'b0; vdp_rdata = 8'h00;
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL ra_latch got %h exp a5", cpu_rdata); end
    checks++; if (plog.size() !== 1 || plog[0].cyc !== last_commit + 1)
      begin errors++; $display("FAIL ra_lat got n=%0d cyc=%0d exp 1/%0d", plog.size(), plog[0].cyc, last_commit + 1); end
    cpu_access(1'b1, 2'd1, 8'h00, rd);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL ra_cpu got %h exp a5", rd); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] rd;
    vdp_ready = 1'b0; idle(4); plog.delete();
    for (int i = 0; i < 4; i++) cpu_access(1'b0, 2'd0, 8'h30 + 8'(i), rd);
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL sim_full0 got %b exp 1", fifo_full); end
    cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 2'd2; cpu_wdata = 8'h34; cpu_phi2 = 1'b1;
    idle(2);
    vdp_ready = 1'b1; cpu_phi2 = 1'b0;
    @(negedge clk);
    cpu_cs = 1'b0;
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL sim_full1 got %b exp 1", fifo_full); end
    checks++; if (vdp_write !== 1'b1 || vdp_data !== 8'h30)
      begin errors++; $display("FAIL sim_pop got write=%b data=%h exp 1/30", vdp_write, vdp_data); end
    idle(7);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_ovf got %b exp 0", overflow); end
    checks++; if (plog.size() !== 5) begin errors++; $display("FAIL sim_count got %0d exp 5", plog.size()); end
    checks++; if (plog[4].data !== 8'h34 || plog[4].mode !== 2'd2)
      begin errors++; $display("FAIL sim_last got data=%h mode=%h exp 34/2", plog[4].data, plog[4].mode); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL sim_drained got %b exp 0", fifo_full); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    vdp_ready = 1'b0; idle(3);
    for (int i = 0; i < 3; i++) cpu_access(1'b0, 2'd3, 8'h50 + 8'(i), rd);
    plog.delete();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (cpu_rdata !== 8'h00 || vdp_mode !== 2'd0 || vdp_data !== 8'h00)
      begin errors++; $display("FAIL mid_regs got rdata=%h mode=%h data=%h exp 00/0/00", cpu_rdata, vdp_mode, vdp_data); end
    checks++; if (vdp_write !== 1'b0 || vdp_read !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b0)
      begin errors++; $display("FAIL mid_flags got w=%b r=%b full=%b ovf=%b exp 0000", vdp_write, vdp_read, fifo_full, overflow); end
    reset = 1'b0; vdp_ready = 1'b1;
    idle(6);
    checks++; if (plog.size() !== 0) begin errors++; $display("FAIL mid_nopulse got %0d exp 0", plog.size()); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL mid_full got %b exp 0", fifo_full); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_register_program();
    test_backpressure();
    test_overflow();
    test_read_ahead();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
